// File: rtl/dac_dual_spi_tx.sv
// Dual-channel SPI transmitter for a two-channel DAC.
// One pending sample pair is buffered. Each frame shifts 16 bits per channel, MSB
// first, on a shared sclk and sync_n. sclk idles high and data is held stable
// across the falling edge, which is where the DAC samples.
module dac_dual_spi_tx #(
  parameter int SCLK_HALF  = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] x_in,
  input  logic [11:0] y_in,
  input  logic        in_stb,
  output logic        sclk,
  output logic        sync_n,
  output logic        dina,
  output logic        dinb,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Last cycle index inside one bit, the length of the sclk-high half, and the last gap cycle
  localparam logic [4:0] CNT_LAST = 5'(2 * SCLK_HALF - 1);
  localparam logic [4:0] HALF_LEN = 5'(SCLK_HALF);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t      state_r;
  logic [11:0] pend_x_r;
  logic [11:0] pend_y_r;
  logic        pend_v_r;
  logic [15:0] shift_a_r;
  logic [15:0] shift_b_r;
  logic [4:0]  cnt_r;
  logic [3:0]  bit_r;
  logic [3:0]  gap_r;
  logic        consume_s;
  logic [4:0]  cnt_next_s;

  // The pending buffer is taken by the FSM whenever it sits in IDLE with a valid entry
  always_comb begin
    consume_s  = 1'b0;
    cnt_next_s = cnt_r + 5'd1;
    if ((state_r == IDLE) && pend_v_r) begin
      consume_s = 1'b1;
    end else begin
      consume_s = 1'b0;
    end
  end

  // One-entry pending buffer and saturating overwrite counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_x_r <= 12'd0;
      pend_y_r <= 12'd0;
      pend_v_r <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (in_stb) begin
      pend_x_r <= x_in;
      pend_y_r <= y_in;
      pend_v_r <= 1'b1;
      // A same-cycle consume moves the old sample out, so nothing is lost then
      if (pend_v_r && !consume_s && (drop_cnt != 8'd255)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end else if (consume_s) begin
      pend_v_r <= 1'b0;
    end
  end

  // Frame FSM: every output is produced here as a register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      sclk       <= 1'b1;
      sync_n     <= 1'b1;
      dina       <= 1'b0;
      dinb       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      shift_a_r  <= 16'd0;
      shift_b_r  <= 16'd0;
      cnt_r      <= 5'd0;
      bit_r      <= 4'd0;
      gap_r      <= 4'd0;
    end else begin
      frame_done <= 1'b0;
      case (state_r)
        IDLE: begin
          sclk   <= 1'b1;
          sync_n <= 1'b1;
          dina   <= 1'b0;
          dinb   <= 1'b0;
          if (pend_v_r) begin
            shift_a_r <= {4'b0000, pend_x_r};
            shift_b_r <= {4'b0000, pend_y_r};
            cnt_r     <= 5'd0;
            bit_r     <= 4'd0;
            sync_n    <= 1'b0;
            busy      <= 1'b1;
            state_r   <= SHIFT;
          end else begin
            busy <= 1'b0;
          end
        end
        SHIFT: begin
          if (cnt_r == CNT_LAST) begin
            // End of the low half: advance to the next bit, or close the frame
            shift_a_r <= {shift_a_r[14:0], 1'b0};
            shift_b_r <= {shift_b_r[14:0], 1'b0};
            cnt_r     <= 5'd0;
            sclk      <= 1'b1;
            if (bit_r == 4'd15) begin
              bit_r   <= 4'd0;
              gap_r   <= 4'd0;
              sync_n  <= 1'b1;
              dina    <= 1'b0;
              dinb    <= 1'b0;
              state_r <= GAP;
            end else begin
              bit_r <= bit_r + 4'd1;
              dina  <= shift_a_r[14];
              dinb  <= shift_b_r[14];
            end
          end else begin
            cnt_r <= cnt_next_s;
            sclk  <= (cnt_next_s < HALF_LEN);
            // The pulse lands on the final cycle of the last bit's low half
            if ((bit_r == 4'd15) && (cnt_next_s == CNT_LAST)) begin
              frame_done <= 1'b1;
            end else begin
              frame_done <= 1'b0;
            end
          end
        end
        GAP: begin
          sclk   <= 1'b1;
          sync_n <= 1'b1;
          if (gap_r == GAP_LAST) begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            gap_r <= gap_r + 4'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          sclk    <= 1'b1;
          sync_n  <= 1'b1;
          dina    <= 1'b0;
          dinb    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dac_dual_spi_tx.md
DAC_DUAL_SPI_TX -- requirements
Module: dac_dual_spi_tx

Interface
REQ-001 The block SHALL have parameter SCLK_HALF, default 2: clk cycles per SCLK half-period, legal values 1..15.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 2: clk cycles sync_n is held high between frames, legal values 1..15.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, exactly as listed in REQ-004 and REQ-005.
REQ-004 Port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port x_in, input, 12 bits: channel A sample, unsigned offset-binary (cos result + 0x800).
REQ-007 Port y_in, input, 12 bits: channel B sample, unsigned offset-binary (sin result + 0x800).
REQ-008 Port in_stb, input, 1 bit: single-cycle strobe marking x_in/y_in valid; there is no backpressure.
REQ-009 Port sclk, output, 1 bit: serial clock shared by both DAC channels; idles high.
REQ-010 Port sync_n, output, 1 bit: active-low frame select shared by both channels.
REQ-011 Port dina, output, 1 bit: serial data for channel A, MSB first.
REQ-012 Port dinb, output, 1 bit: serial data for channel B, MSB first.
REQ-013 Port busy, output, 1 bit: high while the FSM is in any state other than IDLE.
REQ-014 Port frame_done, output, 1 bit: one-cycle pulse on the last cycle of SHIFT.
REQ-015 Port drop_cnt, output, 8 bits: count of overwritten pending samples, saturating at 255.
REQ-016 All outputs SHALL be driven directly from registers.

Function
REQ-017 The pending buffer SHALL be one entry (pend_x, pend_y, pend_v); in_stb=1 SHALL write x_in/y_in into it and set pend_v.
REQ-018 If in_stb=1 while pend_v=1 and the buffer is not consumed that cycle, the buffer SHALL be overwritten and drop_cnt incremented (hold at 255).
REQ-019 If in_stb=1 in the same cycle the buffer is consumed, the new sample SHALL become pending, pend_v SHALL remain 1, and drop_cnt SHALL NOT change.
REQ-020 FSM states SHALL be IDLE, SHIFT and GAP.
REQ-021 IDLE: sync_n=1, sclk=1, dina=dinb=0; when pend_v=1, load shift_a={4'b0000,pend_x} and shift_b={4'b0000,pend_y}, clear pend_v (subject to REQ-019), and go to SHIFT.
REQ-022 SHIFT SHALL transmit 16 bits; each bit SHALL last 2*SCLK_HALF cycles: sclk=1 for the first SCLK_HALF cycles, then 0 for SCLK_HALF cycles.
REQ-023 dina/dinb SHALL equal shift_a[15]/shift_b[15] throughout each bit, so data is stable across the sclk falling edge where the DAC samples.
REQ-024 At the end of each bit's low half, both shift registers SHALL shift left by one.
REQ-025 After the low half of bit 0, frame_done SHALL pulse, and the FSM SHALL go to GAP with sclk=1 and sync_n=1.
REQ-026 sync_n SHALL be low for exactly 32*SCLK_HALF cycles per frame, which is 64 cycles at the default.
REQ-027 GAP SHALL last GAP_CYCLES cycles, then go to IDLE.
REQ-028 Strobe-to-sync_n-low latency from an idle, empty state SHALL be 2 cycles: strobe at edge t, pend_v at t+1, sync_n low from t+2.
REQ-029 A frame, once started, SHALL never be aborted or altered by in_stb; only rst aborts it.

Reset
REQ-030 While rst=1 at a clk edge, the block SHALL set state=IDLE, sclk=1, sync_n=1, dina=0, dinb=0, busy=0, frame_done=0, drop_cnt=0, pend_v=0, and clear the shift registers and counters.
REQ-031 Reset asserted mid-frame SHALL drive sync_n high on the next clk edge, with no further sclk edges and the pending sample discarded.
REQ-032 in_stb SHALL be ignored in any cycle where rst=1.

Verification
REQ-033 Single frame, defaults, x_in=0xABC, y_in=0x123, one strobe -> on 16 sclk falling edges, dina=0000_1010_1011_1100 and dinb=0000_0001_0010_0011; sync_n low 64 cycles; one frame_done pulse; drop_cnt=0.
REQ-034 Strobes every 10 cycles (0x100, 0x200, ...) during one frame -> only the last strobe before frame end is transmitted next; drop_cnt equals strobes-in-frame minus 1.
REQ-035 Strobe in the same cycle IDLE consumes the pending buffer -> the old sample is sent, the new sample is sent in the following frame, and drop_cnt is unchanged.
REQ-036 rst=1 for one cycle during bit 7 of a frame -> next cycle sync_n=1, sclk=1, busy=0, drop_cnt=0, and no frame starts without a new strobe.
REQ-037 300 overrun strobes with SCLK_HALF=1, GAP_CYCLES=1 -> drop_cnt saturates at 255, and every frame has sync_n low for exactly 32 cycles.
